// File: rtl/line_read_buffer_if.sv
// CPU data port and physical-memory read port of the line read buffer, bundled.
// The buffer sits on the slave side; whoever plays CPU and memory takes the master side.
interface line_read_buffer_if;
  logic [15:0]  mem_address;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_address, pmem_read
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_address, pmem_read
  );
endinterface

// File: rtl/line_read_buffer.sv
// Single-line read buffer: serves CPU word reads from a held 128-bit line, fetches on a
// miss, and merges snooped CPU byte writes into the held line so it never goes stale.
module line_read_buffer (
  input logic                clk,
  input logic                reset_n,
  line_read_buffer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  state_t        state_r, state_s;
  logic [127:0]  line_r, line_s;
  logic [11:0]   tag_r, tag_s;
  logic          valid_r, valid_s;
  logic [15:0]   rdata_r, rdata_s;

  logic [11:0]   req_tag_s;
  logic [2:0]    req_off_s;
  logic          hit_s;
  logic          unused_s;

  function automatic logic [15:0] get_word(input logic [127:0] line, input logic [2:0] off);
    return line[{off, 4'b0000} +: 16];
  endfunction

  function automatic logic [127:0] merge_word(input logic [127:0] line, input logic [2:0] off,
                                              input logic [1:0] be, input logic [15:0] wdata);
    logic [127:0] merged;
    merged = line;
    if (be[1]) begin
      merged[{off, 4'b1000} +: 8] = wdata[15:8];
    end else begin
      merged = merged;
    end
    if (be[0]) begin
      merged[{off, 4'b0000} +: 8] = wdata[7:0];
    end else begin
      merged = merged;
    end
    return merged;
  endfunction

  assign req_tag_s = bus.mem_address[15:4];
  assign req_off_s = bus.mem_address[3:1];
  assign hit_s     = valid_r && (tag_r == req_tag_s);
  // Byte lane select within a word is carried by the byte enables, not the address LSB.
  assign unused_s  = bus.mem_address[0];

  // Next-state and next-datapath decode.
  always_comb begin
    state_s = state_r;
    line_s  = line_r;
    tag_s   = tag_r;
    valid_s = valid_r;
    rdata_s = rdata_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.mem_read) begin
          // A read wins over a simultaneous write; the write is dropped.
          if (hit_s) begin
            rdata_s = get_word(line_r, req_off_s);
            state_s = ST_RESP;
          end else begin
            valid_s = 1'b0;
            tag_s   = req_tag_s;
            state_s = ST_FETCH;
          end
        end else if (bus.mem_write && hit_s) begin
          line_s = merge_word(line_r, req_off_s, bus.mem_byte_enable, bus.mem_wdata);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (bus.pmem_resp) begin
          line_s  = bus.pmem_rdata;
          valid_s = 1'b1;
          rdata_s = get_word(bus.pmem_rdata, req_off_s);
          state_s = ST_RESP;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      line_r  <= 128'h0;
      tag_r   <= 12'h000;
      valid_r <= 1'b0;
      rdata_r <= 16'h0000;
    end else begin
      state_r <= state_s;
      line_r  <= line_s;
      tag_r   <= tag_s;
      valid_r <= valid_s;
      rdata_r <= rdata_s;
    end
  end

  // Outputs come straight from registers or decoded state; no input reaches them combinationally.
  assign bus.mem_rdata    = rdata_r;
  assign bus.mem_resp     = (state_r == ST_RESP);
  assign bus.pmem_read    = (state_r == ST_FETCH);
  assign bus.pmem_address = {tag_r, 4'b0000};

endmodule

// File: tb/tb_line_read_buffer.sv
// Randomized self-checking bench for line_read_buffer against a word-array buffer model
// and a sparse physical-memory model.
module tb_line_read_buffer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  line_read_buffer_if bus ();

  line_read_buffer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: held line as eight words, plus physical memory keyed by tag.
  logic [15:0]  m_words [8];
  logic [11:0]  m_tag;
  logic         m_valid;
  logic [15:0]  m_rdata;
  logic [127:0] pmem_lines [logic [11:0]];
  logic [11:0]  tag_pool [3];

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic get_line(input logic [11:0] t, output logic [127:0] l);
    if (!pmem_lines.exists(t)) begin
      pmem_lines[t] = {$urandom, $urandom, $urandom, $urandom};
    end
    l = pmem_lines[t];
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_words[k] = 16'h0000;
    m_tag   = 12'h000;
    m_valid = 1'b0;
    m_rdata = 16'h0000;
  endtask

  task automatic idle_inputs();
    bus.mem_address     = 16'h0000;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 2'b00;
    bus.mem_wdata       = 16'h0000;
    bus.pmem_rdata      = 128'h0;
    bus.pmem_resp       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Read transaction; inputs change only at negedges, outputs are sampled there too.
  task automatic do_read(input logic [15:0] addr, input int waits, input bit with_write);
    logic [127:0] l;
    bit exp_hit;
    exp_hit = m_valid && (m_tag == addr[15:4]);
    bus.mem_address     = addr;
    bus.mem_read        = 1'b1;
    bus.mem_write       = with_write;
    bus.mem_byte_enable = with_write ? 2'b11 : 2'b00;
    bus.mem_wdata       = 16'($urandom);
    @(negedge clk);
    if (!exp_hit) begin
      check_val("fetch_rise", bus.pmem_read, 1'b1);
      check_val("fetch_addr", bus.pmem_address, {addr[15:4], 4'h0});
      check_val("no_resp_in_fetch", bus.mem_resp, 1'b0);
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        check_val("fetch_hold", {bus.pmem_read, bus.pmem_address}, {1'b1, addr[15:4], 4'h0});
        check_val("wait_no_resp", bus.mem_resp, 1'b0);
      end
      get_line(addr[15:4], l);
      bus.pmem_rdata = l;
      bus.pmem_resp  = 1'b1;
      @(negedge clk);
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      m_valid = 1'b1;
      m_tag   = addr[15:4];
      for (int k = 0; k < 8; k++) m_words[k] = l[16*k +: 16];
    end
    m_rdata = m_words[addr[3:1]];
    check_val("pmem_read_low_at_resp", bus.pmem_read, 1'b0);
    check_val("resp", bus.mem_resp, 1'b1);
    check_val("rdata", bus.mem_rdata, m_rdata);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    check_val("resp_one_cycle", bus.mem_resp, 1'b0);
    check_val("rdata_hold", bus.mem_rdata, m_rdata);
  endtask

  // Snooped write, optionally with a stray pmem_resp that an idle buffer must ignore.
  task automatic do_write(input logic [15:0] addr, input logic [1:0] be,
                          input logic [15:0] data, input bit stray_resp);
    bus.mem_address     = addr;
    bus.mem_write       = 1'b1;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = data;
    bus.pmem_resp       = stray_resp;
    bus.pmem_rdata      = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.mem_write = 1'b0;
    bus.pmem_resp = 1'b0;
    if (m_valid && m_tag == addr[15:4]) begin
      if (be[1]) m_words[addr[3:1]][15:8] = data[15:8];
      if (be[0]) m_words[addr[3:1]][7:0]  = data[7:0];
    end
    check_val("write_no_resp", bus.mem_resp, 1'b0);
    check_val("write_no_fetch", bus.pmem_read, 1'b0);
    check_val("write_rdata_hold", bus.mem_rdata, m_rdata);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    pmem_lines[12'h123] = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    tag_pool[0] = 12'h123;
    tag_pool[1] = 12'h800;
    tag_pool[2] = 12'hABC;

    do_reset();
    check_val("reset_pmem_read", bus.pmem_read, 1'b0);
    check_val("reset_pmem_addr", bus.pmem_address, 16'h0000);
    check_val("reset_resp", bus.mem_resp, 1'b0);
    check_val("reset_rdata", bus.mem_rdata, 16'h0000);

    // Directed sequence.
    do_read(16'h1236, 3, 1'b0);
    check_val("cold_read_value", bus.mem_rdata, 16'h3333);
    do_read(16'h123E, 0, 1'b0);
    check_val("hit_value", bus.mem_rdata, 16'h7777);
    do_write(16'h1232, 2'b10, 16'hABCD, 1'b0);
    do_read(16'h1232, 0, 1'b0);
    check_val("merge_value", bus.mem_rdata, 16'hAB11);
    do_write(16'h4560, 2'b11, 16'hFFFF, 1'b0);
    do_read(16'h1230, 0, 1'b0);
    check_val("untouched_word", bus.mem_rdata, 16'h0000);
    do_read(16'h8000, 1, 1'b0);
    do_read(16'h1230, 0, 1'b0);
    check_val("refetch_value", bus.mem_rdata, 16'h0000);
    do_read(16'h1234, 0, 1'b1);
    check_val("rw_pre_write", bus.mem_rdata, 16'h2222);
    do_read(16'h1234, 0, 1'b0);
    check_val("rw_unmodified", bus.mem_rdata, 16'h2222);

    // Reset while a fetch is outstanding, then a late pmem_resp.
    bus.mem_address = 16'hABC8;
    bus.mem_read    = 1'b1;
    @(negedge clk);
    check_val("midfetch_pmem_read", bus.pmem_read, 1'b1);
    reset_n      = 1'b0;
    bus.mem_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    check_val("midfetch_drop", bus.pmem_read, 1'b0);
    check_val("midfetch_resp", bus.mem_resp, 1'b0);
    check_val("midfetch_rdata", bus.mem_rdata, 16'h0000);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    check_val("late_resp_ignored", bus.mem_resp, 1'b0);
    check_val("late_resp_no_fetch", bus.pmem_read, 1'b0);
    do_read(16'hABC8, 2, 1'b0);

    // Randomized mix of reads, snoops, stray responses and idle cycles.
    for (int it = 0; it < 300; it++) begin
      logic [15:0] a;
      int op;
      a  = {tag_pool[$urandom_range(2, 0)], 4'($urandom)};
      op = $urandom_range(9, 0);
      if (op < 4) begin
        do_read(a, $urandom_range(3, 0), ($urandom_range(9, 0) == 0));
      end else if (op < 8) begin
        do_write(a, 2'($urandom), 16'($urandom), ($urandom_range(3, 0) == 0));
      end else begin
        @(negedge clk);
        check_val("idle_resp", bus.mem_resp, 1'b0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
